// File: rtl/rggen_irq_controller_ex.sv
// Interrupt controller for generated register blocks: synchronised sources, edge/level
// capture into sticky status, W1C clear, registered IRQ with hold-off gap and lowest pending ID.
module rggen_irq_controller_ex #(
  parameter int                          TOTAL_INTERRUPTS = 8,
  parameter logic [TOTAL_INTERRUPTS-1:0] EDGE_MASK        = '0,
  parameter int                          SYNC_STAGES      = 2,
  parameter int                          HOLDOFF_WIDTH    = 8,
  parameter int                          ID_WIDTH         = $clog2((TOTAL_INTERRUPTS > 1) ? TOTAL_INTERRUPTS : 2)
)(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [TOTAL_INTERRUPTS-1:0] i_irq_src,
  input  logic [TOTAL_INTERRUPTS-1:0] i_ier,
  input  logic [TOTAL_INTERRUPTS-1:0] i_isr_clear,
  input  logic [HOLDOFF_WIDTH-1:0]    i_holdoff,
  output logic [TOTAL_INTERRUPTS-1:0] o_isr,
  output logic                        o_irq,
  output logic [ID_WIDTH-1:0]         o_irq_id,
  output logic                        o_irq_id_valid
);

  localparam int N = TOTAL_INTERRUPTS;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    HOLDOFF
  } state_t;

  logic [N-1:0]             src_sync;
  logic [N-1:0]             prev;
  logic [N-1:0]             set;
  logic [N-1:0]             pending;
  logic [ID_WIDTH-1:0]      id_next;
  state_t                   state;
  state_t                   state_next;
  logic [HOLDOFF_WIDTH-1:0] cnt;
  logic [HOLDOFF_WIDTH-1:0] cnt_next;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign src_sync = i_irq_src;
    end else begin : g_sync
      logic [N-1:0] sync_q [SYNC_STAGES];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
          sync_q[0] <= i_irq_src;
          for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
      end

      assign src_sync = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // prev resets to 0, so a source already high at release counts as a rising edge
  assign set     = (src_sync & ~prev & EDGE_MASK) | (src_sync & ~EDGE_MASK);
  assign pending = o_isr & i_ier;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev  <= '0;
      o_isr <= '0;
    end else begin
      prev  <= src_sync;
      o_isr <= set | (o_isr & ~i_isr_clear);
    end
  end

  // descending scan so the lowest pending index is the last one written
  always_comb begin
    id_next = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pending[N-1-i]) id_next = ID_WIDTH'(N-1-i);
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (|pending) state_next = ACTIVE;
      end
      ACTIVE: begin
        if (pending == '0) begin
          if (i_holdoff == '0) begin
            state_next = IDLE;
          end else begin
            state_next = HOLDOFF;
            cnt_next   = i_holdoff;
          end
        end
      end
      HOLDOFF: begin
        cnt_next = cnt - HOLDOFF_WIDTH'(1);
        if (cnt == HOLDOFF_WIDTH'(1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      o_irq          <= 1'b0;
      o_irq_id       <= '0;
      o_irq_id_valid <= 1'b0;
    end else begin
      state          <= state_next;
      cnt            <= cnt_next;
      o_irq          <= (state_next == ACTIVE);
      o_irq_id       <= id_next;
      o_irq_id_valid <= |pending;
    end
  end

endmodule

// File: tb/tb_rggen_irq_controller_ex.sv
// Directed bench for rggen_irq_controller_ex: N=4, sources 0/1 edge, 2/3 level, two sync stages.
module tb_rggen_irq_controller_ex;

  logic       clk;
  logic       rst_n;
  logic [3:0] irq_src;
  logic [3:0] ier;
  logic [3:0] isr_clear;
  logic [7:0] holdoff;
  logic [3:0] isr;
  logic       irq;
  logic [1:0] irq_id;
  logic       irq_id_valid;

  int checks;
  int errors;

  rggen_irq_controller_ex #(
    .TOTAL_INTERRUPTS (4),
    .EDGE_MASK        (4'b0011),
    .SYNC_STAGES      (2),
    .HOLDOFF_WIDTH    (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_irq_src      (irq_src),
    .i_ier          (ier),
    .i_isr_clear    (isr_clear),
    .i_holdoff      (holdoff),
    .o_isr          (isr),
    .o_irq          (irq),
    .o_irq_id       (irq_id),
    .o_irq_id_valid (irq_id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    irq_src   = '0;
    ier       = 4'hF;
    isr_clear = '0;
    holdoff   = 8'd0;

    // reset state
    tick(2);
    chk("rst_isr", isr, 4'h0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_id", irq_id, 2'd0);
    chk("rst_valid", irq_id_valid, 1'b0);
    rst_n = 1'b1;
    tick(2);

    // level capture on src[2]: isr after 3 edges, irq one edge later
    irq_src = 4'b0100;
    tick(2);
    chk("lvl_isr_early", isr, 4'h0);
    tick(1);
    chk("lvl_isr", isr, 4'h4);
    chk("lvl_irq_early", irq, 1'b0);
    tick(1);
    chk("lvl_irq", irq, 1'b1);
    chk("lvl_id", irq_id, 2'd2);
    chk("lvl_valid", irq_id_valid, 1'b1);
    isr_clear = 4'b0100;
    tick(1);
    isr_clear = '0;
    chk("lvl_clr_src_high", isr, 4'h4);
    irq_src = '0;
    tick(3);
    chk("lvl_sticky", isr, 4'h4);
    isr_clear = 4'b0100;
    tick(1);
    isr_clear = '0;
    chk("lvl_cleared", isr, 4'h0);
    tick(1);
    chk("lvl_irq_drop", irq, 1'b0);
    chk("lvl_valid_drop", irq_id_valid, 1'b0);

    // edge capture on src[0], held high
    irq_src = 4'b0001;
    tick(3);
    chk("edge_isr", isr, 4'h1);
    tick(7);
    chk("edge_isr_held", isr, 4'h1);
    isr_clear = 4'b0001;
    tick(1);
    isr_clear = '0;
    chk("edge_clr", isr, 4'h0);
    tick(3);
    chk("edge_no_reset", isr, 4'h0);
    irq_src = '0;
    tick(3);
    irq_src = 4'b0001;
    tick(3);
    chk("edge_new_rise", isr, 4'h1);
    isr_clear = 4'b0001;
    tick(1);
    isr_clear = '0;
    irq_src   = '0;
    tick(4);
    chk("edge_idle", isr, 4'h0);

    // set/clear collision on src[1]
    irq_src = 4'b0010;
    tick(3);
    chk("coll_first", isr, 4'h2);
    irq_src = '0;
    tick(3);
    irq_src = 4'b0010;
    tick(2);
    isr_clear = 4'b0010;
    tick(1);
    isr_clear = '0;
    chk("coll_set_wins", isr, 4'h2);
    tick(1);
    chk("coll_sticky", isr, 4'h2);
    isr_clear = 4'b0010;
    tick(1);
    isr_clear = '0;
    irq_src   = '0;
    chk("coll_cleared", isr, 4'h0);
    tick(3);

    // hold-off of 5: isr[2] cleared at edge E while isr[3] sets at E+1
    irq_src = 4'b0100;
    tick(5);
    chk("ho_irq_on", irq, 1'b1);
    irq_src = '0;
    tick(3);
    holdoff = 8'd5;
    irq_src = 4'b1000;
    tick(1);
    isr_clear = 4'b0100;
    tick(1);
    isr_clear = '0;
    chk("ho_isr_clear", isr, 4'h0);
    chk("ho_irq_e", irq, 1'b1);
    tick(1);
    chk("ho_isr_new", isr, 4'h8);
    chk("ho_irq_e1", irq, 1'b0);
    tick(1);
    chk("ho_irq_e2", irq, 1'b0);
    chk("ho_id_in_holdoff", irq_id, 2'd3);
    chk("ho_valid_in_holdoff", irq_id_valid, 1'b1);
    for (int k = 3; k <= 6; k++) begin
      tick(1);
      chk($sformatf("ho_irq_e%0d", k), irq, 1'b0);
    end
    tick(1);
    chk("ho_irq_e7", irq, 1'b1);

    // hold-off of 0: low only for one cycle
    irq_src = '0;
    tick(3);
    holdoff = 8'd0;
    irq_src = 4'b0100;
    tick(1);
    isr_clear = 4'b1000;
    tick(1);
    isr_clear = '0;
    chk("ho0_isr_clear", isr, 4'h0);
    chk("ho0_irq_e", irq, 1'b1);
    tick(1);
    chk("ho0_isr_new", isr, 4'h4);
    chk("ho0_irq_e1", irq, 1'b0);
    tick(1);
    chk("ho0_irq_e2", irq, 1'b1);

    // priority and enable
    irq_src = '0;
    tick(3);
    isr_clear = 4'b0100;
    tick(1);
    isr_clear = '0;
    irq_src   = 4'b1010;
    tick(3);
    irq_src = '0;
    tick(1);
    chk("pri_isr", isr, 4'b1010);
    chk("pri_id", irq_id, 2'd1);
    chk("pri_valid", irq_id_valid, 1'b1);
    holdoff = 8'd3;
    ier     = 4'b1000;
    tick(1);
    chk("pri_id_masked", irq_id, 2'd3);
    ier = 4'h0;
    tick(1);
    chk("pri_valid_off", irq_id_valid, 1'b0);
    chk("pri_irq_off", irq, 1'b0);
    chk("pri_isr_kept", isr, 4'b1010);
    ier = 4'hF;
    tick(1);
    chk("pri_ho_ignore1", irq, 1'b0);
    chk("pri_id_back", irq_id, 2'd1);
    tick(1);
    chk("pri_ho_ignore2", irq, 1'b0);
    tick(1);
    chk("pri_ho_ignore3", irq, 1'b0);
    tick(1);
    chk("pri_irq_back", irq, 1'b1);

    // reset in the middle of hold-off with src[0] (edge) and src[3] (level) high
    irq_src = 4'b1001;
    ier     = 4'h0;
    tick(1);
    ier = 4'hF;
    #3;
    rst_n = 1'b0;
    #1;
    chk("mrst_isr", isr, 4'h0);
    chk("mrst_irq", irq, 1'b0);
    chk("mrst_id", irq_id, 2'd0);
    chk("mrst_valid", irq_id_valid, 1'b0);
    tick(2);
    chk("mrst_isr_held", isr, 4'h0);
    chk("mrst_irq_held", irq, 1'b0);
    rst_n = 1'b1;
    tick(2);
    chk("mrst_isr_early", isr, 4'h0);
    tick(1);
    chk("mrst_isr_set", isr, 4'b1001);
    tick(1);
    chk("mrst_irq_on", irq, 1'b1);
    chk("mrst_id_on", irq_id, 2'd0);
    chk("mrst_valid_on", irq_id_valid, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rggen_irq_controller_ex.md
Name: rggen_irq_controller_ex

Overview:
- Parametrised interrupt controller for generated register blocks. Supersedes the plain ier/isr OR-reduction.
- Adds:
  - per-source input synchronisation;
  - per-source level or rising-edge capture into sticky status bits;
  - software clear;
  - a registered IRQ output with a programmable hold-off gap;
  - a lowest-index pending ID.
- Sits beside the host interface. ier comes from enable bit fields, clear pulses come from W1C bit-field writes, and o_isr feeds read-only status fields.

Parameters:
- TOTAL_INTERRUPTS, 8: number of sources N (1..64).
- EDGE_MASK, {N{1'b0}}: per-source mode; bit i=1 means rising-edge capture, 0 means level capture.
- SYNC_STAGES, 2: synchroniser flops per source (0..3); 0 means the source is used directly.
- HOLDOFF_WIDTH, 8: width of the hold-off counter and of i_holdoff.
- ID_WIDTH, $clog2(N>1?N:2): width of o_irq_id.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- i_irq_src  input  N  raw interrupt sources; may be asynchronous when SYNC_STAGES>0.
- i_ier  input  N  per-source enable.
- i_isr_clear  input  N  one-cycle write-1-to-clear strobes for status bits.
- i_holdoff  input  HOLDOFF_WIDTH  minimum o_irq low cycles after deassertion; sampled on ACTIVE->HOLDOFF.
- o_isr  output  N  sticky status register.
- o_irq  output  1  registered interrupt request.
- o_irq_id  output  ID_WIDTH  index of the lowest-numbered pending source (registered).
- o_irq_id_valid  output  1  registered; 1 when any source is pending.

Behaviour:
- Reset (async assert, sync release):
  - All synchroniser flops, edge history, isr, state (IDLE), counter, o_irq, o_irq_id and o_irq_id_valid go to 0.
  - A source already high at reset release is treated as a rising edge and as an asserted level.
- Synchroniser: s[i] is i_irq_src[i] delayed by SYNC_STAGES flops.
- Capture condition:
  - Edge source: set[i] = s[i] & ~prev[i]; prev[i] <= s[i] every cycle.
  - Level source: set[i] = s[i].
- Status update: isr[i] <= set[i] | (isr[i] & ~i_isr_clear[i]).
  - Set wins over a simultaneous clear.
  - A level source still high re-sets its bit the cycle after the clear.
- Latency: raw source edge to o_isr is SYNC_STAGES+1 cycles; o_irq follows one cycle later.
- pending = isr & i_ier, combinational. Disabling ier drops pending immediately; isr is kept.
- State machine (o_irq is 1 only in ACTIVE, registered):
  - IDLE: if |pending, go to ACTIVE.
  - ACTIVE: if pending==0, then:
    - if i_holdoff==0, go to IDLE;
    - otherwise go to HOLDOFF and load cnt=i_holdoff.
  - HOLDOFF:
    - o_irq=0; pending is ignored;
    - cnt decrements each cycle; when cnt==1, go to IDLE.
    - HOLDOFF therefore lasts exactly i_holdoff cycles.
- Resulting gap: minimum o_irq low time between pulses is i_holdoff+1 cycles when pending re-asserts at once.
- o_irq_id / o_irq_id_valid:
  - Registered every cycle from pending, independent of state.
  - id = lowest i with pending[i]; 0 when none.
- Width rules:
  - N=1 gives ID_WIDTH=1 and id is always 0.
  - The counter never wraps; cnt==0 is unreachable in HOLDOFF.
- Mid-operation reset: any state returns to IDLE and all outputs drop to 0 asynchronously.

Test Plan:
- Level capture: N=4, SYNC_STAGES=2, all level, ier=4'hF. Raise src[2] at cycle 0.
  - o_isr=4'h4 at cycle 3; o_irq=1 and o_irq_id=2 at cycle 4.
  - Pulse clear[2] with src still high: isr[2] stays 1. Drop src, then clear: o_isr=0 next cycle.
- Edge capture: EDGE_MASK=4'h1. Hold src[0] high 10 cycles.
  - isr[0] sets once.
  - Clear while src remains high: isr[0] stays 0 until a new 0->1 edge.
- Set/clear collision: new edge on src[1] in the same cycle as clear[1] -> isr[1] remains 1.
- Hold-off: i_holdoff=5, clear all pending at cycle t while another source sets immediately.
  - o_irq=0 for cycles t+1..t+6, re-asserts at t+7.
  - Repeat with i_holdoff=0: o_irq low only at t+1, high at t+2.
- Priority/enable: isr=4'b1010, ier=4'hF -> o_irq_id=1.
  - ier=4'b1000 -> id=3 next cycle.
  - ier=0 -> o_irq_id_valid=0 and o_irq enters HOLDOFF; isr still reads 4'b1010.
- Reset mid-HOLDOFF with src[3] high:
  - All outputs 0 during reset.
  - After release, isr[3] sets SYNC_STAGES+1 cycles later (edge and level modes).
